// File: rtl/shift_reg_ctrl.sv
// Byte sequencer for an external 8-bit shift register: serializes a byte at DIV clocks per bit while sampling ser_in full-duplex.
// Optional even-parity bit is enabled by defining SHIFT_CTRL_PARITY_EN.
module shift_reg_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       lsb_first,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_parity_err,
  output logic       busy,
  output logic       ser_out,
  input  logic       ser_in,
  output logic       sr_load,
  output logic       sr_shift,
  output logic       sr_dir,
  output logic       sr_ser_in,
  output logic [7:0] sr_data,
  input  logic [7:0] sr_q
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(DIV / 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef SHIFT_CTRL_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t        state, state_next;
  logic [7:0]    byte_r;
  logic          dir_r;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          rx_bit;
  logic [7:0]    rx_data_r;
  logic          in_bit_period;

`ifdef SHIFT_CTRL_PARITY_EN
  assign in_bit_period = (state == SHIFT) || (state == PARITY);
`else
  assign in_bit_period = (state == SHIFT);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_r    <= '0;
      dir_r     <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rx_bit    <= 1'b0;
      rx_data_r <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && tx_valid) begin
        byte_r <= tx_data;
        dir_r  <= lsb_first;
      end
      if (state == LOAD) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (in_bit_period) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        if (div_cnt == DIV_MID) rx_bit <= ser_in;
        if (state == SHIFT && div_cnt == DIV_LAST) bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == DONE) rx_data_r <= sr_q;
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch.
  always_comb begin
    state_next    = state;
    tx_ready      = 1'b0;
    busy          = (state != IDLE);
    ser_out       = 1'b1;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    sr_dir        = (state != IDLE) && dir_r;
    sr_ser_in     = 1'b0;
    sr_data       = '0;
    rx_valid      = 1'b0;
    rx_data       = rx_data_r;
    rx_parity_err = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_next = LOAD;
      end
      LOAD: begin
        sr_load    = 1'b1;
        sr_data    = byte_r;
        state_next = SHIFT;
      end
      SHIFT: begin
        ser_out = dir_r ? sr_q[0] : sr_q[7];
        if (div_cnt == DIV_LAST) begin
          sr_shift  = 1'b1;
          // With DIV=2 the sample and the shift share an edge, so bypass rx_bit.
          sr_ser_in = (DIV_MID == DIV_LAST) ? ser_in : rx_bit;
          if (bit_cnt == 3'd7) begin
`ifdef SHIFT_CTRL_PARITY_EN
            state_next = PARITY;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef SHIFT_CTRL_PARITY_EN
      PARITY: begin
        ser_out = ^byte_r;
        if (div_cnt == DIV_LAST) state_next = DONE;
      end
`endif
      DONE: begin
        rx_valid   = 1'b1;
        rx_data    = sr_q;
`ifdef SHIFT_CTRL_PARITY_EN
        rx_parity_err = rx_bit ^ (^sr_q);
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
